multi_channel_pulse_width_detector: RTL and testbench
=====================================================

// Module: multi_channel_pulse_width_detector
// PURPOSE
//  N-channel generalisation of the one-cycle (010) pulse detector. Each channel
//  qualifies pulses of selectable polarity whose width lies in [MIN_W, MAX_W].
//  For each qualified pulse it emits a one-cycle registered strobe and the
//  measured width. Out-of-range pulses are reported separately.
//  Sits behind input synchronisers, feeding event counters and interrupt logic.
// PARAMETERS
//  N_CH   4                      number of independent channels
//  MIN_W  1                      shortest accepted pulse, in cycles (>=1)
//  MAX_W  8                      longest accepted pulse, in cycles (>=MIN_W)
//  CNT_W  $clog2(MAX_W+1)        width counter / width_o field width (derived)
// PORTS
//  clk          in   1           clock, all logic on posedge
//  rst          in   1           synchronous reset, active-high
//  a            in   N_CH        per-channel input, already synchronous to clk
//  polarity     in   N_CH        0: detect high pulses (0-1..1-0); 1: detect low pulses
//  detected     out  N_CH        one-cycle strobe: in-range pulse has ended
//  width_o      out  N_CH*CNT_W  channel i at [i*CNT_W +: CNT_W]; width of last
//                                in-range pulse
//  reject_short out  N_CH        one-cycle strobe: ended pulse had W < MIN_W
//  reject_long  out  N_CH        one-cycle strobe: run reached MAX_W+1 cycles
// BEHAVIOUR
//  - Per channel: level l = a[i] ^ pol_r[i], where pol_r is polarity registered
//    each cycle. Widths count sampled clock edges at l==1.
//  - Per-channel FSM states: ARM, IDLE, ACTIVE, OVER.
//    ARM    : l==0 -> IDLE. A run already active at reset is never reported.
//    IDLE   : l==1 -> ACTIVE, cnt=1.
//    ACTIVE : l==1 and cnt<MAX_W -> cnt++.
//             l==1 and cnt==MAX_W -> OVER, reject_long=1 next cycle.
//             l==0 -> IDLE. If cnt>=MIN_W: detected=1, width_o=cnt.
//             Otherwise: reject_short=1.
//    OVER   : l==0 -> IDLE, no strobe. Stays while l==1; cnt saturates, no wrap.
//  - Output timing: all outputs are registered. A strobe is high for exactly the
//    cycle after the clock edge that sampled the terminating value.
//    The 010 case gives latency 1 from the edge sampling the trailing 0.
//  - width_o updates only together with detected and holds until the next detection.
//  - Back-to-back pulses (e.g. 0,1,0,1,0) report every pulse. The trailing idle
//    sample of one pulse serves as the leading idle sample of the next.
//  - A polarity[i] change (polarity[i] != pol_r[i]) forces channel i to ARM and
//    suppresses all strobes that cycle. It wins over a simultaneous pulse end.
//  - Reset (including mid-pulse) sets all FSMs to ARM and cnt=0. It clears
//    detected/reject_short/reject_long/width_o to 0 and pol_r to 0. A pulse
//    straddling reset is not reported.
//  - At most one of detected/reject_short/reject_long is high per channel per cycle.
//  - Channels are fully independent; no cross-channel arbitration.
// STRUCTURE
//  - Package pulse_det_pkg: enum logic[1:0] {ARM, IDLE, ACTIVE, OVER}
//    pulse_state_t. Also holds the parameter legality check (MIN_W<=MAX_W, MIN_W>=1).
//  - Sub-module pulse_width_channel: one FSM plus counter plus output regs.
//  - Top level instantiates it N_CH times via generate.
// TESTING
//  1. ch0 pol=0, MIN=1, MAX=8. Drive a[0]=0,1,0 after reset.
//     -> detected[0]=1 for exactly one cycle, 1 cycle after trailing 0 sampled;
//        width_o[0]=1.
//  2. a[0]=1 held through reset release for 3 cycles, then 0.
//     -> no strobe (ARM). Then 0,1,1,0 -> detected, width=2.
//  3. High run of 8 -> detected, width=8.
//     High run of 9 -> reject_long on the cycle after the 9th high sample,
//     no detected on return to 0.
//  4. MIN_W=3 build: runs of 2 and 3.
//     -> reject_short for the 2-run; detected with width=3 for the 3-run.
//  5. ch1 pol=1: a[1]=1,0,0,1 -> detected[1], width=2. ch0 quiet meanwhile.
//     Toggle polarity[1] while its pulse ends -> no strobe that cycle.
//  6. Reset asserted mid-pulse (4th high cycle) -> all outputs 0 next cycle,
//     no later strobe for that pulse. Then 0,1,0,1,0 -> two detected strobes.

Source files
------------

// File: rtl/pulse_det_pkg.sv
// ============================================================================
// pulse_det_pkg : shared state encoding and parameter legality check
// Rev 1.0
// ============================================================================
`default_nettype none

package pulse_det_pkg;

  typedef enum logic [1:0] {
    ARM    = 2'd0,
    IDLE   = 2'd1,
    ACTIVE = 2'd2,
    OVER   = 2'd3
  } pulse_state_t;

  function automatic bit params_legal(input int min_w, input int max_w);
    return (min_w >= 1) && (min_w <= max_w);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pulse_width_channel.sv
// ============================================================================
// pulse_width_channel : one-channel pulse width qualifier
// Rev 1.0
// ============================================================================
`default_nettype none

module pulse_width_channel
  import pulse_det_pkg::*;
#(
  parameter int MIN_W = 1,
  parameter int MAX_W = 8,
  parameter int CNT_W = $clog2(MAX_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             polarity,
  output logic             detected,
  output logic [CNT_W-1:0] width_o,
  output logic             reject_short,
  output logic             reject_long
);

  localparam logic [CNT_W-1:0] c_MIN_W = CNT_W'(MIN_W);
  localparam logic [CNT_W-1:0] c_MAX_W = CNT_W'(MAX_W);

  pulse_state_t     r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pol;
  logic             w_lvl;
  logic             w_pol_chg;

  assign w_lvl     = a ^ r_pol;
  assign w_pol_chg = polarity != r_pol;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ARM;
      r_cnt        <= '0;
      r_pol        <= 1'b0;
      detected     <= 1'b0;
      width_o      <= '0;
      reject_short <= 1'b0;
      reject_long  <= 1'b0;
    end else begin
      r_pol        <= polarity;
      detected     <= 1'b0;
      reject_short <= 1'b0;
      reject_long  <= 1'b0;
      // A polarity change restarts qualification and overrides any pulse end.
      if (w_pol_chg) begin
        r_state <= ARM;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          ARM: begin
            if (!w_lvl) r_state <= IDLE;
          end
          IDLE: begin
            if (w_lvl) begin
              r_state <= ACTIVE;
              r_cnt   <= CNT_W'(1);
            end
          end
          ACTIVE: begin
            if (w_lvl) begin
              if (r_cnt == c_MAX_W) begin
                r_state     <= OVER;
                reject_long <= 1'b1;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end else begin
              r_state <= IDLE;
              if (r_cnt >= c_MIN_W) begin
                detected <= 1'b1;
                width_o  <= r_cnt;
              end else begin
                reject_short <= 1'b1;
              end
            end
          end
          OVER: begin
            if (!w_lvl) r_state <= IDLE;
          end
          default: r_state <= ARM;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/multi_channel_pulse_width_detector.sv
// ============================================================================
// multi_channel_pulse_width_detector : N independent pulse width qualifiers
// Rev 1.0
// ============================================================================
`default_nettype none

module multi_channel_pulse_width_detector
  import pulse_det_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int MIN_W = 1,
  parameter int MAX_W = 8,
  parameter int CNT_W = $clog2(MAX_W + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       a,
  input  logic [N_CH-1:0]       polarity,
  output logic [N_CH-1:0]       detected,
  output logic [N_CH*CNT_W-1:0] width_o,
  output logic [N_CH-1:0]       reject_short,
  output logic [N_CH-1:0]       reject_long
);

  if (!params_legal(MIN_W, MAX_W)) begin : g_bad_params
    $error("pulse detector: need 1 <= MIN_W <= MAX_W");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pulse_width_channel #(
      .MIN_W (MIN_W),
      .MAX_W (MAX_W),
      .CNT_W (CNT_W)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .a            (a[i]),
      .polarity     (polarity[i]),
      .detected     (detected[i]),
      .width_o      (width_o[i*CNT_W +: CNT_W]),
      .reject_short (reject_short[i]),
      .reject_long  (reject_long[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_multi_channel_pulse_width_detector.sv
// ============================================================================
// tb_multi_channel_pulse_width_detector : directed bench, MIN_W=1 and MIN_W=3 builds
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_multi_channel_pulse_width_detector;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  a;
  logic [3:0]  polarity;
  logic [3:0]  det, rs, rl;
  logic [15:0] wo;
  logic [3:0]  det3, rs3, rl3;
  logic [15:0] wo3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multi_channel_pulse_width_detector #(.N_CH(4), .MIN_W(1), .MAX_W(8)) dut (
    .clk(clk), .rst(rst), .a(a), .polarity(polarity),
    .detected(det), .width_o(wo), .reject_short(rs), .reject_long(rl)
  );

  multi_channel_pulse_width_detector #(.N_CH(4), .MIN_W(3), .MAX_W(8)) dut3 (
    .clk(clk), .rst(rst), .a(a), .polarity(polarity),
    .detected(det3), .width_o(wo3), .reject_short(rs3), .reject_long(rl3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; a = 4'h0; polarity = 4'h0;
    step(); step();
    total++;
    if ({det, rs, rl, wo} !== 28'h0) begin
      bad++; $display("FAIL reset_outputs: got %h want 0", {det, rs, rl, wo});
    end
    rst = 1'b0;
  endtask

  task automatic test_single_010();
    a = 4'h0; step();
    a = 4'h1; step();
    total++;
    if (det !== 4'h0) begin bad++; $display("FAIL 010_early: det=%b want 0000", det); end
    a = 4'h0; step();
    total++;
    if (det[0] !== 1'b1 || wo[3:0] !== 4'd1) begin
      bad++; $display("FAIL 010_detect: det0=%b w=%0d want 1/1", det[0], wo[3:0]);
    end
    step();
    total++;
    if (det[0] !== 1'b0) begin bad++; $display("FAIL 010_one_cycle: det0=%b want 0", det[0]); end
  endtask

  task automatic test_arm_through_reset();
    rst = 1'b1; a = 4'h1; step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({det[0], rs[0], rl[0]} !== 3'b000) begin
        bad++; $display("FAIL arm_hold: strobes=%b want 000", {det[0], rs[0], rl[0]});
      end
    end
    a = 4'h0; step();
    total++;
    if ({det[0], rs[0], rl[0]} !== 3'b000) begin
      bad++; $display("FAIL arm_release: strobes=%b want 000", {det[0], rs[0], rl[0]});
    end
    a = 4'h0; step();
    a = 4'h1; step(); step();
    a = 4'h0; step();
    total++;
    if (det[0] !== 1'b1 || wo[3:0] !== 4'd2) begin
      bad++; $display("FAIL arm_then_w2: det0=%b w=%0d want 1/2", det[0], wo[3:0]);
    end
    total++;
    if (rs3[0] !== 1'b1 || det3[0] !== 1'b0) begin
      bad++; $display("FAIL min3_w2_short: rs=%b det=%b want 1/0", rs3[0], det3[0]);
    end
  endtask

  task automatic test_long();
    a = 4'h1;
    for (int i = 0; i < 8; i++) step();
    a = 4'h0; step();
    total++;
    if (det[0] !== 1'b1 || wo[3:0] !== 4'd8 || rl[0] !== 1'b0) begin
      bad++; $display("FAIL run8: det=%b rl=%b w=%0d want 1/0/8", det[0], rl[0], wo[3:0]);
    end
    a = 4'h1;
    for (int i = 0; i < 8; i++) step();
    total++;
    if (rl[0] !== 1'b0) begin bad++; $display("FAIL run9_early: rl=%b want 0", rl[0]); end
    step();
    total++;
    if (rl[0] !== 1'b1 || det[0] !== 1'b0) begin
      bad++; $display("FAIL run9_long: rl=%b det=%b want 1/0", rl[0], det[0]);
    end
    step();
    total++;
    if (rl[0] !== 1'b0) begin bad++; $display("FAIL run9_one_cycle: rl=%b want 0", rl[0]); end
    a = 4'h0; step();
    total++;
    if ({det[0], rs[0], rl[0]} !== 3'b000 || wo[3:0] !== 4'd8) begin
      bad++; $display("FAIL run9_end: strobes=%b w=%0d want 000/8", {det[0], rs[0], rl[0]}, wo[3:0]);
    end
  endtask

  task automatic test_min3();
    a = 4'h0; step();
    a = 4'h1; step(); step();
    a = 4'h0; step();
    total++;
    if (rs3[0] !== 1'b1 || det3[0] !== 1'b0) begin
      bad++; $display("FAIL min3_run2: rs=%b det=%b want 1/0", rs3[0], det3[0]);
    end
    a = 4'h1; step(); step(); step();
    a = 4'h0; step();
    total++;
    if (det3[0] !== 1'b1 || rs3[0] !== 1'b0 || wo3[3:0] !== 4'd3) begin
      bad++; $display("FAIL min3_run3: det=%b rs=%b w=%0d want 1/0/3", det3[0], rs3[0], wo3[3:0]);
    end
  endtask

  task automatic test_low_polarity();
    polarity = 4'b0010; a = 4'b0010; step();
    a = 4'b0010; step();
    a = 4'b0000; step(); step();
    a = 4'b0010; step();
    total++;
    if (det !== 4'b0010 || wo[7:4] !== 4'd2) begin
      bad++; $display("FAIL ch1_low_w2: det=%b w1=%0d want 0010/2", det, wo[7:4]);
    end
    a = 4'b0010; step();
    a = 4'b0000; step(); step();
    a = 4'b0010; polarity = 4'b0000; step();
    total++;
    if ({det[1], rs[1], rl[1]} !== 3'b000 || wo[7:4] !== 4'd2) begin
      bad++; $display("FAIL pol_change_suppress: strobes=%b w1=%0d want 000/2", {det[1], rs[1], rl[1]}, wo[7:4]);
    end
    a = 4'b0000;
  endtask

  task automatic test_back_to_back();
    step(); step();
    a = 4'h1; step(); step(); step();
    rst = 1'b1; step();
    total++;
    if ({det, rs, rl, wo} !== 28'h0) begin
      bad++; $display("FAIL mid_pulse_reset: got %h want 0", {det, rs, rl, wo});
    end
    rst = 1'b0;
    step(); step();
    a = 4'h0; step();
    total++;
    if (det !== 4'h0) begin bad++; $display("FAIL straddle_unreported: det=%b want 0000", det); end
    a = 4'h1; step();
    a = 4'h0; step();
    total++;
    if (det[0] !== 1'b1 || wo[3:0] !== 4'd1) begin
      bad++; $display("FAIL b2b_first: det0=%b w=%0d want 1/1", det[0], wo[3:0]);
    end
    a = 4'h1; step();
    total++;
    if (det[0] !== 1'b0) begin bad++; $display("FAIL b2b_gap: det0=%b want 0", det[0]); end
    a = 4'h0; step();
    total++;
    if (det[0] !== 1'b1 || wo[3:0] !== 4'd1) begin
      bad++; $display("FAIL b2b_second: det0=%b w=%0d want 1/1", det[0], wo[3:0]);
    end
  endtask

  initial begin
    test_reset();
    test_single_010();
    test_arm_through_reset();
    test_long();
    test_min3();
    test_low_polarity();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
